// File: rtl/async_fifo_pkg.sv
// ---------------------------------------------------------------------------
// async_fifo_pkg
// Shared types and constants for the write side of the async FIFO.
//   fifo_word_t  : {id, last, data} word layout at the default widths
//   arb_state_e  : write-port arbiter states
//   PKT_CNT_WIDTH: width of the completed-packet counter
// ---------------------------------------------------------------------------
package async_fifo_pkg;

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_ID_WIDTH   = $clog2(DEF_NUM_REQ);

    localparam int unsigned PKT_CNT_WIDTH  = 16;

    typedef struct packed {
        logic [DEF_ID_WIDTH-1:0]   id;
        logic                      last;
        logic [DEF_DATA_WIDTH-1:0] data;
    } fifo_word_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/async_fifo_wr_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Stateless rotating-priority picker. Returns the first set request found
// when searching upward from ptr, wrapping modulo NUM_REQ.
//   req       : per-source request bits
//   ptr       : highest-priority index (must be < NUM_REQ)
//   grant_idx : index of the winning source (0 when any_req is 0)
//   any_req   : at least one request is set
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [ID_WIDTH-1:0] grant_idx,
    output logic                any_req
);

    always_comb begin
        int unsigned          idx;
        logic [ID_WIDTH-1:0]  cand;
        grant_idx = '0;
        any_req   = 1'b0;
        idx       = 0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            // ptr < NUM_REQ, so one conditional subtract is enough to wrap;
            // this also keeps non-power-of-2 NUM_REQ correct.
            idx = 32'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = ID_WIDTH'(idx);
            if (!any_req && req[cand]) begin
                any_req   = 1'b1;
                grant_idx = cand;
            end
        end
    end

endmodule

// File: rtl/async_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// async_fifo_wr_arbiter
// Shares the async FIFO write port among NUM_REQ packet sources with
// packet-granular round-robin arbitration. The granted source is forwarded
// to the FIFO combinationally; each word carries {id, last, data}.
//   wclk, wrst     : write clock, async active-high reset
//   req_valid/last/data, req_ready : per-source packet beat handshake
//   fifo_w_valid/data, fifo_w_ready: FIFO write port
//   owner, locked  : current/last granted source, packet in progress
//   pkt_count      : completed packets (wrapping)
//   err_oversize   : sticky, packet reached MAX_PKT_BEATS beats without last
// ---------------------------------------------------------------------------
module async_fifo_wr_arbiter
    import async_fifo_pkg::*;
#(
    parameter  int unsigned NUM_REQ       = 4,
    parameter  int unsigned DATA_WIDTH    = 8,
    parameter  int unsigned MAX_PKT_BEATS = 16,
    localparam int unsigned ID_WIDTH      = $clog2(NUM_REQ),
    localparam int unsigned FIFO_WIDTH    = DATA_WIDTH + ID_WIDTH + 1
) (
    input  logic                          wclk,
    input  logic                          wrst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_w_valid,
    output logic [FIFO_WIDTH-1:0]         fifo_w_data,
    input  logic                          fifo_w_ready,
    output logic [ID_WIDTH-1:0]           owner,
    output logic                          locked,
    output logic [PKT_CNT_WIDTH-1:0]      pkt_count,
    output logic                          err_oversize
);

    localparam int unsigned BCW = $clog2(MAX_PKT_BEATS + 1);

    arb_state_e               state_q,     state_d;
    logic [ID_WIDTH-1:0]      owner_q,     owner_d;
    logic [ID_WIDTH-1:0]      rr_ptr_q,    rr_ptr_d;
    logic [BCW-1:0]           beat_cnt_q,  beat_cnt_d;
    logic [PKT_CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;
    logic                     err_q,       err_d;

    logic [ID_WIDTH-1:0]      winner;
    logic                     any_req;
    logic [ID_WIDTH-1:0]      g;
    logic                     g_active;
    logic                     g_last;
    logic                     accept;

    function automatic logic [ID_WIDTH-1:0] next_id(input logic [ID_WIDTH-1:0] id);
        return (32'(id) == NUM_REQ - 1) ? '0 : id + 1'b1;
    endfunction

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant_idx (winner),
        .any_req   (any_req)
    );

    // State register
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            pkt_count_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            pkt_count_q <= pkt_count_d;
            err_q       <= err_d;
        end
    end

    // Output / forwarding path: owner while locked, live winner while idle.
    always_comb begin
        g            = (state_q == LOCKED) ? owner_q : winner;
        g_active     = !wrst && ((state_q == LOCKED) || any_req);
        g_last       = req_last[g];
        fifo_w_valid = g_active && req_valid[g];
        fifo_w_data  = {g, g_last, req_data[32'(g)*DATA_WIDTH +: DATA_WIDTH]};
        req_ready    = '0;
        if (g_active) begin
            req_ready[g] = fifo_w_ready;
        end
        accept       = fifo_w_valid && fifo_w_ready;
        locked       = (state_q == LOCKED);
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        pkt_count_d = pkt_count_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = winner;
                    if (accept && g_last) begin
                        rr_ptr_d    = next_id(winner);
                        pkt_count_d = pkt_count_q + 1'b1;
                    end else begin
                        // Latch even on a stalled offer so the grant cannot
                        // move while the FIFO applies backpressure.
                        state_d    = LOCKED;
                        beat_cnt_d = accept ? BCW'(1) : '0;
                    end
                end
            end
            LOCKED: begin
                if (accept) begin
                    if (g_last) begin
                        state_d     = IDLE;
                        rr_ptr_d    = next_id(owner_q);
                        beat_cnt_d  = '0;
                        pkt_count_d = pkt_count_q + 1'b1;
                    end else if (beat_cnt_q != BCW'(MAX_PKT_BEATS)) begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                        if (beat_cnt_q == BCW'(MAX_PKT_BEATS - 1)) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign owner        = owner_q;
    assign pkt_count    = pkt_count_q;
    assign err_oversize = err_q;

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
module tb_async_fifo_wr_arbiter;
    import async_fifo_pkg::*;

    logic        wclk;
    logic        wrst;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_w_valid;
    logic [10:0] fifo_w_data;
    logic        fifo_w_ready;
    logic [1:0]  owner;
    logic        locked;
    logic [15:0] pkt_count;
    logic        err_oversize;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;
    fifo_word_t  exp_q[$];

    async_fifo_wr_arbiter #(
        .NUM_REQ       (4),
        .DATA_WIDTH    (8),
        .MAX_PKT_BEATS (16)
    ) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_w_valid (fifo_w_valid),
        .fifo_w_data  (fifo_w_data),
        .fifo_w_ready (fifo_w_ready),
        .owner        (owner),
        .locked       (locked),
        .pkt_count    (pkt_count),
        .err_oversize (err_oversize)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic fifo_word_t mk(input logic [1:0] id, input logic last, input logic [7:0] d);
        return {id, last, d};
    endfunction

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic samp();
        @(negedge wclk);
    endtask

    // Scoreboard monitor: every word the FIFO will accept at the next edge
    // is compared against the head of the expected queue.
    always @(negedge wclk) begin
        if (fifo_w_valid === 1'b1 && fifo_w_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got 0x%0h expected none", fifo_w_data);
            end else begin
                check("fifo_word", 32'(fifo_w_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset ----------------
        wrst         = 1'b1;
        req_valid    = 4'hF;
        req_last     = 4'hF;
        req_data     = '0;
        fifo_w_ready = 1'b1;
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = 8'h10 + 8'(i);
        repeat (2) samp();
        check("rst_ready", 32'(req_ready), 0);
        check("rst_wvalid", 32'(fifo_w_valid), 0);
        check("rst_pkt", 32'(pkt_count), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_owner", 32'(owner), 0);
        check("rst_err", 32'(err_oversize), 0);

        // ---------------- round robin, 1-beat packets ----------------
        exp_q.push_back(mk(2'd0, 1'b1, 8'h10));
        exp_q.push_back(mk(2'd1, 1'b1, 8'h11));
        exp_q.push_back(mk(2'd2, 1'b1, 8'h12));
        exp_q.push_back(mk(2'd3, 1'b1, 8'h13));
        exp_q.push_back(mk(2'd0, 1'b1, 8'h10));
        tick();
        wrst = 1'b0;
        samp();
        check("rr_first_ready", 32'(req_ready), 32'b0001);
        check("rr_first_id", 32'(fifo_w_data[10:9]), 0);
        repeat (5) @(posedge wclk);
        #1 req_valid = '0;
        samp();
        check("rr_pkt", 32'(pkt_count), 5);
        check("rr_idle_wvalid", 32'(fifo_w_valid), 0);
        check("rr_owner", 32'(owner), 0);

        // ---------------- packet lock (src1 3 beats, src2 waiting) ----------
        exp_q.push_back(mk(2'd1, 1'b0, 8'hA1));
        exp_q.push_back(mk(2'd1, 1'b0, 8'hA2));
        exp_q.push_back(mk(2'd1, 1'b1, 8'hA3));
        exp_q.push_back(mk(2'd2, 1'b1, 8'hB2));
        tick();
        req_valid = 4'b0110;
        req_last  = 4'b0100;
        req_data[8 +: 8]  = 8'hA1;
        req_data[16 +: 8] = 8'hB2;
        samp();
        check("lock_b0_ready", 32'(req_ready), 32'b0010);
        check("lock_b0_locked", 32'(locked), 0);
        tick();
        req_data[8 +: 8] = 8'hA2;
        samp();
        check("lock_b1_locked", 32'(locked), 1);
        check("lock_b1_ready", 32'(req_ready), 32'b0010);
        tick();
        req_data[8 +: 8] = 8'hA3;
        req_last[1] = 1'b1;
        samp();
        check("lock_b2_locked", 32'(locked), 1);
        check("lock_b2_ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b0100;
        samp();
        check("lock_done_locked", 32'(locked), 0);
        check("lock_src2_ready", 32'(req_ready), 32'b0100);
        check("lock_pkt", 32'(pkt_count), 6);
        tick();
        req_valid = '0;
        samp();
        check("lock_pkt2", 32'(pkt_count), 7);
        check("lock_owner", 32'(owner), 2);

        // ---------------- backpressure on src3 ----------------
        exp_q.push_back(mk(2'd3, 1'b1, 8'hA5));
        tick();
        fifo_w_ready = 1'b0;
        req_valid    = 4'b1000;
        req_last     = 4'b1001;
        req_data[24 +: 8] = 8'hA5;
        req_data[0 +: 8]  = 8'h77;
        samp();
        check("bp_wvalid", 32'(fifo_w_valid), 1);
        check("bp_ready0", 32'(req_ready), 0);
        tick();
        req_valid = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            samp();
            check("bp_owner", 32'(owner), 3);
            check("bp_locked", 32'(locked), 1);
            check("bp_word", 32'(fifo_w_data), 32'(mk(2'd3, 1'b1, 8'hA5)));
            check("bp_ready", 32'(req_ready), 0);
            tick();
        end
        fifo_w_ready = 1'b1;
        exp_q.push_back(mk(2'd0, 1'b1, 8'h77));
        samp();
        check("bp_release_ready", 32'(req_ready), 32'b1000);
        tick();
        samp();
        check("bp_next_ready", 32'(req_ready), 32'b0001);
        check("bp_next_locked", 32'(locked), 0);
        check("bp_pkt", 32'(pkt_count), 8);
        tick();
        req_valid = '0;
        samp();
        check("bp_pkt2", 32'(pkt_count), 9);

        // ---------------- oversize packet: 20 beats then last ----------------
        for (int b = 1; b <= 21; b++) exp_q.push_back(mk(2'd2, 1'(b == 21), 8'h40 + 8'(b)));
        tick();
        for (int b = 1; b <= 21; b++) begin
            req_valid = 4'b0100;
            req_last  = (b == 21) ? 4'b0100 : 4'b0000;
            req_data[16 +: 8] = 8'h40 + 8'(b);
            samp();
            if (b == 16) check("ovs_before", 32'(err_oversize), 0);
            if (b == 17) check("ovs_set", 32'(err_oversize), 1);
            if (b == 21) check("ovs_still_locked", 32'(locked), 1);
            tick();
        end
        req_valid = '0;
        samp();
        check("ovs_pkt", 32'(pkt_count), 10);
        check("ovs_err", 32'(err_oversize), 1);
        check("ovs_idle", 32'(locked), 0);
        repeat (5) tick();
        samp();
        check("ovs_sticky", 32'(err_oversize), 1);

        // ---------------- reset mid-packet ----------------
        exp_q.push_back(mk(2'd1, 1'b0, 8'hC1));
        exp_q.push_back(mk(2'd1, 1'b0, 8'hC2));
        tick();
        req_valid = 4'b0010;
        req_last  = 4'b0000;
        req_data[8 +: 8] = 8'hC1;
        samp();
        check("rm_b0_ready", 32'(req_ready), 32'b0010);
        tick();
        req_data[8 +: 8] = 8'hC2;
        samp();
        check("rm_b1_locked", 32'(locked), 1);
        tick();
        wrst      = 1'b1;
        req_valid = 4'b1011;
        req_data[8 +: 8] = 8'hC3;
        samp();
        check("rm_wvalid", 32'(fifo_w_valid), 0);
        check("rm_ready", 32'(req_ready), 0);
        check("rm_locked", 32'(locked), 0);
        check("rm_owner", 32'(owner), 0);
        check("rm_pkt", 32'(pkt_count), 0);
        check("rm_err", 32'(err_oversize), 0);
        exp_q.push_back(mk(2'd1, 1'b1, 8'hD1));
        exp_q.push_back(mk(2'd3, 1'b1, 8'hD3));
        tick();
        wrst      = 1'b0;
        req_valid = 4'b1010;
        req_last  = 4'b1010;
        req_data[8 +: 8]  = 8'hD1;
        req_data[24 +: 8] = 8'hD3;
        samp();
        check("rm_post_grant", 32'(req_ready), 32'b0010);
        tick();
        samp();
        check("rm_post_next", 32'(req_ready), 32'b1000);
        tick();
        req_valid = '0;
        samp();
        check("rm_post_pkt", 32'(pkt_count), 2);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/async_fifo_wr_arbiter.md
Name: async_fifo_wr_arbiter

Overview:
- Shares the single write port of the async FIFO among NUM_REQ packet sources in the wclk domain.
- Arbitration is round-robin at packet granularity: once a source wins, it owns the port until its last beat is accepted.
- Each forwarded word is tagged with source ID and last flag, so the read-domain consumer can demultiplex packets.
- Keeps a packet counter and an oversize-packet error flag for status.

Parameters:
NUM_REQ, 4, number of requesting sources (>=2)
DATA_WIDTH, 8, payload width per beat
MAX_PKT_BEATS, 16, beat count that sets err_oversize if reached without last (>=2)
ID_WIDTH, $clog2(NUM_REQ), derived source-ID width (localparam)
FIFO_WIDTH, DATA_WIDTH+ID_WIDTH+1, derived FIFO word width (localparam)

Ports:
wclk  in  1  write-domain clock
wrst  in  1  reset, asynchronous, active-high
req_valid  in  NUM_REQ  per-source beat valid
req_last  in  NUM_REQ  per-source last-beat-of-packet flag
req_data  in  NUM_REQ*DATA_WIDTH  per-source payload; source i at [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  NUM_REQ  per-source accept; one-hot or zero
fifo_w_valid  out  1  to FIFO w_valid
fifo_w_data  out  FIFO_WIDTH  {id, last, data} to FIFO w_data
fifo_w_ready  in  1  from FIFO w_ready (~full)
owner  out  ID_WIDTH  current/last granted source
locked  out  1  1 while in LOCKED state
pkt_count  out  16  completed packets, wraps at 0xFFFF->0
err_oversize  out  1  sticky; set when a packet reaches MAX_PKT_BEATS beats without last

Behaviour:
- States: IDLE and LOCKED. Registers: state, owner, rr_ptr, beat_cnt, pkt_count, err_oversize.
- Reset values: state=IDLE, owner=0, rr_ptr=0, beat_cnt=0, pkt_count=0, err_oversize=0, locked=0.
- While wrst is high, req_ready=0 and fifo_w_valid=0 (combinationally gated).
- Grant (IDLE): winner is the first i with req_valid[i]=1, searching from rr_ptr upward modulo NUM_REQ.
- Zero-latency forwarding: the granted source maps combinationally to the FIFO in the same cycle.
  - fifo_w_valid = req_valid[g]
  - fifo_w_data = {g, req_last[g], req_data[g]}
  - req_ready[g] = fifo_w_ready; all other req_ready bits = 0.
- In LOCKED, g=owner. In IDLE, g=winner; if no req_valid is set, fifo_w_valid=0 and req_ready=0.
- Beat accepted when fifo_w_valid && fifo_w_ready.
- IDLE transitions:
  - No request: stay IDLE.
  - Request offered and accepted with last=1: stay IDLE; rr_ptr<=winner+1 (mod NUM_REQ); owner<=winner; pkt_count++.
  - Otherwise (not accepted, or accepted with last=0): go LOCKED; owner<=winner; beat_cnt<=1 if accepted, else 0.
  - Latching on a stalled offer keeps the granted source stable under backpressure.
- LOCKED transitions:
  - Accepted beat with last=1: go IDLE; rr_ptr<=owner+1; beat_cnt<=0; pkt_count++.
  - Accepted beat with last=0: beat_cnt++, saturating at MAX_PKT_BEATS.
  - Owner deasserts valid mid-packet: stay LOCKED with no timeout; other sources wait.
- err_oversize: set when beat_cnt would reach MAX_PKT_BEATS on a non-last accepted beat. The packet is not truncated. Cleared only by wrst.
- rr_ptr advances only on packet completion, never on a stall.
- Requests raised by other sources during LOCKED are ignored until IDLE.
- Packet of length 1 completes in one cycle without entering LOCKED.
- Back-to-back packets: a source completing in LOCKED returns to IDLE. The next grant comes from rr_ptr=owner+1, so the same source wins again only if no other source is valid.
- Wrap: rr_ptr and ID arithmetic are modulo NUM_REQ. For non-power-of-2 NUM_REQ, compare against NUM_REQ-1 explicitly.
- Reset asserted mid-packet: immediately IDLE with no further beats. The FIFO may hold a partial packet; the consumer discards on ID change.

Decomposition:
- async_fifo_pkg holds:
  - fifo_word_t packed struct {id, last, data}, parameterised via localparams on the default widths.
  - PKT_CNT_WIDTH=16.
  - State enum arb_state_e {IDLE, LOCKED}.
- One sub-module, rr_arbiter: combinational rotating-priority picker with inputs req[NUM_REQ] and ptr, outputs grant_idx and any_req. No state, reused on the read side.

Test Plan:
- Reset: hold wrst, drive all req_valid=1 -> req_ready=0000, fifo_w_valid=0, pkt_count=0; release -> source 0 granted first cycle, fifo_w_data id=0.
- Round robin: sources 0-3 each offer continuous 1-beat packets, fifo_w_ready=1 -> ids 0,1,2,3,0 on consecutive cycles; pkt_count=5 after 5 cycles.
- Packet lock: src1 sends 3-beat packet, src2 valid throughout -> ids 1,1,1 then 2; req_ready[2]=0 until src1 last accepted; locked=1 for beats 1-2.
- Backpressure: src3 offers beat 0xA5 with fifo_w_ready=0 for 4 cycles while src0 raises valid -> owner stays 3, fifo_w_data unchanged, locked=1; on ready, 0xA5 with id=3 written.
- Oversize: MAX_PKT_BEATS=16, src2 sends 20 beats then last -> err_oversize rises on the 16th accepted beat, all 21 beats forwarded, pkt_count +1, flag stays set until wrst.
- Reset mid-packet: assert wrst after 2 of 5 beats of src1 -> state IDLE, rr_ptr=0, fifo_w_valid=0 during reset; after release src0 (if valid) wins.
